// File: rtl/rst_seq_ctrl.sv
// Reset sequencer and run watchdog: synchronizes reset release, frees memory then core,
// and freezes in a readable terminal status on error, halt or cycle-limit runaway.
module rst_seq_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 2,
    parameter int MEM_TO_CORE = 1,
    parameter int MAX_CYCLES  = 100000,
    parameter int CNT_W       = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             err,
    input  logic             halt,
    input  logic             soft_rst_req,
    output logic             rst_mem,
    output logic             rst_core,
    output logic             running,
    output logic             stop,
    output logic [1:0]       status,
    output logic [CNT_W-1:0] cycle_count
);

    localparam logic [2:0] ST_HOLD    = 3'd0;
    localparam logic [2:0] ST_MEM     = 3'd1;
    localparam logic [2:0] ST_RUN     = 3'd2;
    localparam logic [2:0] ST_DONE    = 3'd3;
    localparam logic [2:0] ST_FAULT   = 3'd4;
    localparam logic [2:0] ST_TIMEOUT = 3'd5;

    localparam logic [1:0] STAT_NONE    = 2'b00;
    localparam logic [1:0] STAT_HALTED  = 2'b01;
    localparam logic [1:0] STAT_ERROR   = 2'b10;
    localparam logic [1:0] STAT_TIMEOUT = 2'b11;

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int MEM_W  = (MEM_TO_CORE > 1) ? $clog2(MEM_TO_CORE) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [MEM_W-1:0]  MEM_LAST  = MEM_W'(MEM_TO_CORE - 1);
    localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(MAX_CYCLES);

    // Reset-deassert synchronizer: set asynchronously, released through the chain.
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   rst_sync;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], 1'b0};
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rst_sync = sync_q[SYNC_STAGES-1];

    logic [2:0]        state_q,       state_d;
    logic [HOLD_W-1:0] hold_cnt_q,    hold_cnt_d;
    logic [MEM_W-1:0]  mem_cnt_q,     mem_cnt_d;
    logic              rst_mem_q,     rst_mem_d;
    logic              rst_core_q,    rst_core_d;
    logic              running_q,     running_d;
    logic              stop_q,        stop_d;
    logic [1:0]        status_q,      status_d;
    logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
    logic              restart;

    // NOTE: every always_comb output gets a hold-value default first, so no path infers a latch.
    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        mem_cnt_d     = mem_cnt_q;
        rst_mem_d     = rst_mem_q;
        rst_core_d    = rst_core_q;
        running_d     = running_q;
        stop_d        = stop_q;
        status_d      = status_q;
        cycle_count_d = cycle_count_q;
        restart       = 1'b0;

        case (state_q)
            ST_HOLD: begin
                if (rst_sync) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d   = ST_MEM;
                    rst_mem_d = 1'b0;
                    mem_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end

            ST_MEM: begin
                if (mem_cnt_q == MEM_LAST) begin
                    state_d       = ST_RUN;
                    rst_core_d    = 1'b0;
                    running_d     = 1'b1;
                    cycle_count_d = '0;
                end else begin
                    mem_cnt_d = mem_cnt_q + MEM_W'(1);
                end
            end

            ST_RUN: begin
                if (err) begin
                    state_d   = ST_FAULT;
                    status_d  = STAT_ERROR;
                    running_d = 1'b0;
                    stop_d    = 1'b1;
                end else if (halt) begin
                    state_d   = ST_DONE;
                    status_d  = STAT_HALTED;
                    running_d = 1'b0;
                    stop_d    = 1'b1;
                end else if (cycle_count_q == CNT_LIMIT) begin
                    state_d   = ST_TIMEOUT;
                    status_d  = STAT_TIMEOUT;
                    running_d = 1'b0;
                    stop_d    = 1'b1;
                end else if (soft_rst_req) begin
                    restart = 1'b1;
                end else begin
                    cycle_count_d = cycle_count_q + CNT_W'(1);
                end
            end

            // Terminal states keep the core out of reset so its state can be inspected.
            ST_DONE, ST_FAULT, ST_TIMEOUT: begin
                restart = soft_rst_req;
            end

            default: begin
                restart = 1'b1;
            end
        endcase

        // Soft restart re-enters HOLD; the synchronizer is already released.
        if (restart) begin
            state_d       = ST_HOLD;
            hold_cnt_d    = '0;
            mem_cnt_d     = '0;
            rst_mem_d     = 1'b1;
            rst_core_d    = 1'b1;
            running_d     = 1'b0;
            stop_d        = 1'b0;
            status_d      = STAT_NONE;
            cycle_count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_HOLD;
            hold_cnt_q    <= '0;
            mem_cnt_q     <= '0;
            rst_mem_q     <= 1'b1;
            rst_core_q    <= 1'b1;
            running_q     <= 1'b0;
            stop_q        <= 1'b0;
            status_q      <= STAT_NONE;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            mem_cnt_q     <= mem_cnt_d;
            rst_mem_q     <= rst_mem_d;
            rst_core_q    <= rst_core_d;
            running_q     <= running_d;
            stop_q        <= stop_d;
            status_q      <= status_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    assign rst_mem     = rst_mem_q;
    assign rst_core    = rst_core_q;
    assign running     = running_q;
    assign stop        = stop_q;
    assign status      = status_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: two instances (default limit and limit 10) share stimulus and are
// compared every cycle against an edge-counting model, plus hand-computed literal checks.
module tb_rst_seq_ctrl;

    localparam int SYNC  = 2;
    localparam int HOLD  = 2;
    localparam int M2C   = 1;
    localparam int MAX_A = 100000;
    localparam int MAX_T = 10;

    logic clk = 1'b0;
    logic rst;
    logic err;
    logic halt;
    logic soft_rst_req;

    logic        a_rst_mem, a_rst_core, a_running, a_stop;
    logic [1:0]  a_status;
    logic [16:0] a_cycle_count;
    logic        t_rst_mem, t_rst_core, t_running, t_stop;
    logic [1:0]  t_status;
    logic [3:0]  t_cycle_count;

    int checks   = 0;
    int failures = 0;

    always #50 clk = ~clk;

    rst_seq_ctrl dut_a (
        .clk(clk), .rst(rst), .err(err), .halt(halt), .soft_rst_req(soft_rst_req),
        .rst_mem(a_rst_mem), .rst_core(a_rst_core), .running(a_running), .stop(a_stop),
        .status(a_status), .cycle_count(a_cycle_count)
    );

    rst_seq_ctrl #(.MAX_CYCLES(MAX_T), .CNT_W(4)) dut_t (
        .clk(clk), .rst(rst), .err(err), .halt(halt), .soft_rst_req(soft_rst_req),
        .rst_mem(t_rst_mem), .rst_core(t_rst_core), .running(t_running), .stop(t_stop),
        .status(t_status), .cycle_count(t_cycle_count)
    );

    // Model: edges elapsed since the sequence started, the release latency for that start,
    // and a frozen terminal record. Everything else follows arithmetically.
    typedef struct packed {
        int         seq_edges;
        int         lat;
        logic       terminal;
        logic [1:0] term;
        int         frozen;
    } mdl_t;

    function automatic mdl_t mdl_start(input int lat);
        mdl_t m;
        m.seq_edges = 0;
        m.lat       = lat;
        m.terminal  = 1'b0;
        m.term      = 2'b00;
        m.frozen    = 0;
        return m;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t m, input int maxc,
                                      input logic e, input logic h, input logic s);
        mdl_t n;
        int   rs;
        int   cnt;
        n  = m;
        rs = m.lat + M2C;
        if (m.terminal) begin
            if (s) n = mdl_start(HOLD);
        end else if (m.seq_edges >= rs) begin
            cnt = m.seq_edges - rs;
            if (e) begin
                n.terminal = 1'b1; n.term = 2'b10; n.frozen = cnt;
            end else if (h) begin
                n.terminal = 1'b1; n.term = 2'b01; n.frozen = cnt;
            end else if (cnt == maxc) begin
                n.terminal = 1'b1; n.term = 2'b11; n.frozen = cnt;
            end else if (s) begin
                n = mdl_start(HOLD);
            end else begin
                n.seq_edges = m.seq_edges + 1;
            end
        end else begin
            n.seq_edges = m.seq_edges + 1;
        end
        return n;
    endfunction

    function automatic logic [63:0] mdl_out(input mdl_t m);
        int   rs;
        logic mem_free, core_free;
        int   cnt;
        rs        = m.lat + M2C;
        mem_free  = m.terminal || (m.seq_edges >= m.lat);
        core_free = m.terminal || (m.seq_edges >= rs);
        if (m.terminal)         cnt = m.frozen;
        else if (core_free)     cnt = m.seq_edges - rs;
        else                    cnt = 0;
        return {26'd0, !mem_free, !core_free, core_free && !m.terminal, m.terminal, m.term, cnt};
    endfunction

    mdl_t m_a = mdl_start(SYNC + HOLD);
    mdl_t m_t = mdl_start(SYNC + HOLD);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_a <= mdl_start(SYNC + HOLD);
            m_t <= mdl_start(SYNC + HOLD);
        end else begin
            m_a <= mdl_step(m_a, MAX_A, err, halt, soft_rst_req);
            m_t <= mdl_step(m_t, MAX_T, err, halt, soft_rst_req);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("cycle_a", {26'd0, a_rst_mem, a_rst_core, a_running, a_stop, a_status,
                          32'(a_cycle_count)}, mdl_out(m_a));
        check("cycle_t", {26'd0, t_rst_mem, t_rst_core, t_running, t_stop, t_status,
                          32'(t_cycle_count)}, mdl_out(m_t));
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_soft();
        soft_rst_req = 1'b1;
        step(1);
        soft_rst_req = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; err = 1'b0; halt = 1'b0; soft_rst_req = 1'b0;
        #201 rst = 1'b0;

        // Power-on release: rst_mem at edge 4, rst_core/running at edge 5.
        step(3);
        check("pon_mem_e3", a_rst_mem, 1);
        check("pon_core_e3", a_rst_core, 1);
        step(1);
        check("pon_mem_e4", a_rst_mem, 0);
        check("pon_core_e4", a_rst_core, 1);
        check("pon_t_mem_e4", t_rst_mem, 0);
        step(1);
        check("pon_core_e5", a_rst_core, 0);
        check("pon_run_e5", a_running, 1);
        check("pon_cnt_e5", a_cycle_count, 0);
        check("pon_stat_e5", a_status, 0);

        // 37 RUN cycles; the limit-10 instance has timed out by now.
        step(37);
        check("run_cnt37", a_cycle_count, 37);
        check("to_stop", t_stop, 1);
        check("to_status", t_status, 3);
        check("to_cnt", t_cycle_count, 10);
        check("to_running", t_running, 0);

        halt = 1'b1; step(1); halt = 1'b0;
        check("halt_stop", a_stop, 1);
        check("halt_status", a_status, 1);
        check("halt_cnt", a_cycle_count, 37);
        check("halt_running", a_running, 0);
        check("halt_core", a_rst_core, 0);
        step(3);
        check("halt_cnt_hold", a_cycle_count, 37);

        // Soft restart from DONE/TIMEOUT; further pulses in HOLD and MEM are ignored.
        pulse_soft();
        check("sr1_mem", a_rst_mem, 1);
        check("sr1_core", a_rst_core, 1);
        check("sr1_status", a_status, 0);
        check("sr1_stop", a_stop, 0);
        check("sr1_t_status", t_status, 0);
        pulse_soft();
        check("sr1_hold_mem", a_rst_mem, 1);
        pulse_soft();
        check("sr1_mem_rel", a_rst_mem, 0);
        check("sr1_core_held", a_rst_core, 1);
        pulse_soft();
        check("sr1_running", a_running, 1);
        check("sr1_cnt0", a_cycle_count, 0);

        // err and halt together: error wins, later err/halt ignored.
        step(5);
        err = 1'b1; halt = 1'b1; step(1); err = 1'b0; halt = 1'b0;
        check("pri_status", a_status, 2);
        check("pri_stop", a_stop, 1);
        check("pri_cnt", a_cycle_count, 5);
        err = 1'b1; step(2); err = 1'b0; halt = 1'b1; step(1); halt = 1'b0;
        check("pri_status_hold", a_status, 2);
        check("pri_cnt_hold", a_cycle_count, 5);

        // Soft restart from FAULT.
        pulse_soft();
        check("sr2_mem", a_rst_mem, 1);
        check("sr2_core", a_rst_core, 1);
        check("sr2_status", a_status, 0);
        check("sr2_cnt", a_cycle_count, 0);
        step(1);
        check("sr2_mem_e1", a_rst_mem, 1);
        step(1);
        check("sr2_mem_e2", a_rst_mem, 0);
        check("sr2_core_e2", a_rst_core, 1);
        step(1);
        check("sr2_core_e3", a_rst_core, 0);
        check("sr2_cnt0", a_cycle_count, 0);

        // Soft restart from RUN, then hard reset while in MEM.
        step(4);
        pulse_soft();
        check("sr3_mem", a_rst_mem, 1);
        step(2);
        check("mid_mem_rel", a_rst_mem, 0);
        check("mid_core_held", a_rst_core, 1);
        #10 rst = 1'b1;
        #1;
        check("async_mem", a_rst_mem, 1);
        check("async_core", a_rst_core, 1);
        check("async_t_mem", t_rst_mem, 1);
        step(2);
        #1 rst = 1'b0;
        step(3);
        check("rpt_mem_e3", a_rst_mem, 1);
        step(1);
        check("rpt_mem_e4", a_rst_mem, 0);
        check("rpt_core_e4", a_rst_core, 1);
        step(1);
        check("rpt_core_e5", a_rst_core, 0);
        check("rpt_running", a_running, 1);
        step(3);
        check("rpt_cnt3", a_cycle_count, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
